nav_turn_queue_sm: RTL and testbench
====================================

Name: nav_turn_queue_sm

Overview:
- Parametrised successor to the single-player snake navigation state machine.
- Serves NUM_PLAYERS independent players. Each player's direction buttons are edge-detected and legal turns are queued in a per-player FIFO of depth QUEUE_DEPTH.
- The applied direction advances only on the game-step strobe TICK, so rapid key combos between steps are kept, not lost.
- Sits between the button synchronisers and the snake position/collision logic.

Parameters:
- NUM_PLAYERS, 1, number of independent direction channels.
- QUEUE_DEPTH, 2, turn FIFO entries per player (power of two, ≥2).
- RESET_DIR, 2'b00, direction loaded into every channel on reset (encoding below).

Ports:
- CLK  in  1  system clock, rising edge.
- RESETN  in  1  reset, synchronous, active-low.
- TICK  in  1  one-cycle game-step strobe; pops one queued turn per player.
- BTNU  in  NUM_PLAYERS  up button per player (pre-synchronised, level).
- BTNR  in  NUM_PLAYERS  right button per player.
- BTND  in  NUM_PLAYERS  down button per player.
- BTNL  in  NUM_PLAYERS  left button per player.
- DIR  out  2*NUM_PLAYERS  applied direction; player p occupies bits [2p+1:2p].
- TURN_PENDING  out  NUM_PLAYERS  queue of player p is non-empty.
- TURN_DROP  out  NUM_PLAYERS  one-cycle pulse: a legal request was discarded because the queue was full.

Behaviour:
- Encoding:
  - 00 up, 01 right, 10 down, 11 left.
  - opposite(d) = d ^ 2'b10.
- Reset (RESETN=0 at a CLK edge):
  - DIR = RESET_DIR for all players.
  - Queues empty; TURN_PENDING = 0; TURN_DROP = 0.
  - Edge-detect history registers = 1, so buttons already held at reset release generate no request.
  - Reset mid-operation discards all queued turns.
- Edge detection: a request exists in cycle n when the button is 1 in cycle n and was 0 in cycle n-1. Holding a button produces exactly one request.
- Same-cycle priority: if several buttons rise in one cycle for one player, only one is considered, in the order U > R > D > L. The others are ignored and not retried.
- Reference direction (ref):
  - Last queued entry if the queue is non-empty, otherwise current DIR.
  - Evaluated on the pre-clock state.
- Legality: a request r is legal iff r != ref and r != opposite(ref). Illegal requests are silently ignored (no TURN_DROP).
- Push: a legal request is written at the tail at the clock edge.
- Pop: on TICK with the queue non-empty, DIR <= head and the head is removed. On TICK with the queue empty, DIR holds.
- Latency:
  - A request accepted at edge n reaches DIR no earlier than the first TICK edge after n.
  - Request and TICK in the same cycle with an empty queue: the push lands in the queue and DIR is unchanged that edge; the next TICK applies it.
- Full queue:
  - Without TICK: the legal request is dropped and TURN_DROP pulses for 1 cycle.
  - With TICK in the same cycle: pop and push both occur, and the request is accepted.
- Counters: occupancy counter width clog2(QUEUE_DEPTH)+1. Read/write pointers wrap modulo QUEUE_DEPTH.
- Channels are fully independent: no shared state and no cross-player priority.
- All outputs are registered, with no combinational path from buttons to outputs.

Decomposition:
- Shared package nav_pkg:
  - direction constants DIR_UP/DIR_RIGHT/DIR_DOWN/DIR_LEFT.
  - opposite-direction function.
  - priority-encode function for the four buttons.
- Sub-module nav_turn_channel: one player's edge detect, legality check, FIFO and DIR register. The top instantiates it NUM_PLAYERS times in a generate loop and packs/unpacks the buses.

Test Plan:
- Reset with BTNU held high, RESET_DIR=00 → DIR=00, TURN_PENDING=0. Releasing and re-pressing BTNU produces no push (same as ref).
- From DIR=00: press BTNR, release; press BTND, release; then TICK → DIR=01. Next TICK → DIR=10. TURN_PENDING goes 1→1→0.
- From DIR=01, queue empty: press BTNL → ignored, no TURN_DROP. Next TICK → DIR stays 01.
- QUEUE_DEPTH=2, DIR=00: requests R, D, L with no TICK → R and D queued; L drops with TURN_DROP=1 for exactly 1 cycle. Repeat L in the same cycle as TICK → accepted; the queue then holds D, L.
- BTNU and BTNR rise in the same cycle with DIR=11 → only U considered; U is legal and queued. TICK → DIR=00.
- NUM_PLAYERS=2: player 0 presses R and player 1 presses L in the same cycle, then TICK → DIR = {11, 01}. Asserting RESETN=0 with pending turns clears both queues and sets DIR={00, 00}.

Source files
------------

// File: rtl/nav_pkg.sv
// Shared direction encoding and button helpers for the per-player turn queues.
// Encoding: 00 up, 01 right, 10 down, 11 left; opposite direction flips bit 1.
package nav_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  // One player's four buttons, U in the MSB so packing matches priority order.
  typedef struct packed {
    logic u;
    logic r;
    logic d;
    logic l;
  } btn_t;

  typedef struct packed {
    logic       vld;
    logic [1:0] dir;
  } turn_req_t;

  function automatic logic [1:0] opposite(input logic [1:0] d);
    return d ^ 2'b10;
  endfunction

  // Only one rising button per cycle is considered; U > R > D > L.
  function automatic turn_req_t prio_encode(input btn_t rise);
    turn_req_t req;
    req.vld = 1'b1;
    req.dir = DIR_UP;
    if (rise.u)      req.dir = DIR_UP;
    else if (rise.r) req.dir = DIR_RIGHT;
    else if (rise.d) req.dir = DIR_DOWN;
    else if (rise.l) req.dir = DIR_LEFT;
    else             req.vld = 1'b0;
    return req;
  endfunction

endpackage

// File: rtl/nav_turn_channel.sv
// One player's turn queue: edge detect, legality vs. last queued/applied dir, FIFO, DIR register.
// DIR changes only on TICK with a queued turn; a legal request into a full queue without TICK is dropped and flagged.
module nav_turn_channel
  import nav_pkg::*;
#(
  parameter int         QUEUE_DEPTH = 2,
  parameter logic [1:0] RESET_DIR   = 2'b00
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       TICK,
  input  btn_t       btn,
  output logic [1:0] dir,
  output logic       turn_pending,
  output logic       turn_drop
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(QUEUE_DEPTH);

  logic [1:0]       mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       dir_q;
  logic             pending_q;
  logic             drop_q;
  btn_t             hist_q;
  btn_t             rise;
  turn_req_t        req;
  logic [1:0]       tail_dir;
  logic [1:0]       ref_dir;
  logic             empty;
  logic             full;
  logic             legal;
  logic             push;
  logic             pop;
  logic             drop;

  always_comb begin
    rise     = btn_t'(btn & ~hist_q);
    req      = prio_encode(rise);
    empty    = (cnt_q == '0);
    full     = (cnt_q == DEPTH_CNT);
    tail_dir = mem_q[wr_ptr_q - PTR_W'(1)];
    // New turns are judged against where the snake will be heading once the queue drains.
    ref_dir  = empty ? dir_q : tail_dir;
    legal    = req.vld && (req.dir != ref_dir) && (req.dir != opposite(ref_dir));
    pop      = TICK && !empty;
    push     = legal && (!full || pop);
    drop     = legal && full && !pop;
    cnt_nxt  = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      dir_q     <= RESET_DIR;
      hist_q    <= '1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      hist_q <= btn;
      if (pop) begin
        dir_q    <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
        mem_q[wr_ptr_q] <= req.dir;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      cnt_q     <= cnt_nxt;
      pending_q <= (cnt_nxt != '0);
      drop_q    <= drop;
    end
  end

  assign dir          = dir_q;
  assign turn_pending = pending_q;
  assign turn_drop    = drop_q;

endmodule

// File: rtl/nav_turn_queue_sm.sv
// Multi-player direction state machine: one independent nav_turn_channel per player, buses packed per player.
// Outputs registered; turns applied one per player on each TICK, overflow reported on TURN_DROP.
module nav_turn_queue_sm
  import nav_pkg::*;
#(
  parameter int         NUM_PLAYERS = 1,
  parameter int         QUEUE_DEPTH = 2,
  parameter logic [1:0] RESET_DIR   = 2'b00
) (
  input  logic                     CLK,
  input  logic                     RESETN,
  input  logic                     TICK,
  input  logic [NUM_PLAYERS-1:0]   BTNU,
  input  logic [NUM_PLAYERS-1:0]   BTNR,
  input  logic [NUM_PLAYERS-1:0]   BTND,
  input  logic [NUM_PLAYERS-1:0]   BTNL,
  output logic [2*NUM_PLAYERS-1:0] DIR,
  output logic [NUM_PLAYERS-1:0]   TURN_PENDING,
  output logic [NUM_PLAYERS-1:0]   TURN_DROP
);

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    btn_t btn;
    assign btn = {BTNU[p], BTNR[p], BTND[p], BTNL[p]};

    nav_turn_channel #(
      .QUEUE_DEPTH (QUEUE_DEPTH),
      .RESET_DIR   (RESET_DIR)
    ) u_channel (
      .CLK          (CLK),
      .RESETN       (RESETN),
      .TICK         (TICK),
      .btn          (btn),
      .dir          (DIR[2*p+1:2*p]),
      .turn_pending (TURN_PENDING[p]),
      .turn_drop    (TURN_DROP[p])
    );
  end

endmodule

// File: tb/tb_nav_turn_queue_sm.sv
// Vector table plus reset sequences for a two-player, depth-2 instance; expectations go through a scoreboard queue.
module tb_nav_turn_queue_sm;

  logic       CLK = 1'b0;
  logic       RESETN;
  logic       TICK;
  logic [1:0] BTNU, BTNR, BTND, BTNL;
  logic [3:0] DIR;
  logic [1:0] TURN_PENDING, TURN_DROP;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  nav_turn_queue_sm #(
    .NUM_PLAYERS (2),
    .QUEUE_DEPTH (2),
    .RESET_DIR   (2'b00)
  ) dut (
    .CLK          (CLK),
    .RESETN       (RESETN),
    .TICK         (TICK),
    .BTNU         (BTNU),
    .BTNR         (BTNR),
    .BTND         (BTND),
    .BTNL         (BTNL),
    .DIR          (DIR),
    .TURN_PENDING (TURN_PENDING),
    .TURN_DROP    (TURN_DROP)
  );

  typedef struct {
    logic       tick;
    logic [1:0] u, r, d, l;
    logic [3:0] dir;
    logic [1:0] pend, drop;
  } vec_t;

  typedef struct {
    string      name;
    int         idx;
    logic [3:0] dir;
    logic [1:0] pend, drop;
  } exp_t;

  vec_t vecs[34];
  exp_t sb[$];

  function automatic vec_t mk(input logic tick, input logic [1:0] u, r, d, l,
                              input logic [3:0] dir, input logic [1:0] pend, drop);
    vec_t v;
    v.tick = tick; v.u = u; v.r = r; v.d = d; v.l = l;
    v.dir = dir; v.pend = pend; v.drop = drop;
    return v;
  endfunction

  task automatic cmp(input string name, input int idx, input string what,
                     input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] %s got=%b expected=%b", name, idx, what, got, exp);
    end
  endtask

  // Drive one cycle, record its expectation, then compare once the edge has landed.
  task automatic step(input string name, input int idx, input logic rstn, input vec_t v);
    exp_t e;
    RESETN = rstn; TICK = v.tick;
    BTNU = v.u; BTNR = v.r; BTND = v.d; BTNL = v.l;
    e.name = name; e.idx = idx; e.dir = v.dir; e.pend = v.pend; e.drop = v.drop;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s[%0d] scoreboard empty", name, idx);
    end else begin
      e = sb.pop_front();
      cmp(e.name, e.idx, "DIR", DIR, e.dir);
      cmp(e.name, e.idx, "TURN_PENDING", {2'b00, TURN_PENDING}, {2'b00, e.pend});
      cmp(e.name, e.idx, "TURN_DROP", {2'b00, TURN_DROP}, {2'b00, e.drop});
    end
  endtask

  initial begin
    //                tick  U      R      D      L      DIR      PEND   DROP
    vecs[0]  = mk(0, 2'b11, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00, 2'b00); // U held out of reset
    vecs[1]  = mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00, 2'b00);
    vecs[2]  = mk(0, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00, 2'b00); // U == ref
    vecs[3]  = mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00, 2'b00);
    vecs[4]  = mk(0, 2'b00, 2'b01, 2'b00, 2'b00, 4'b0000, 2'b01, 2'b00); // R queued
    vecs[5]  = mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b01, 2'b00);
    vecs[6]  = mk(0, 2'b00, 2'b00, 2'b01, 2'b00, 4'b0000, 2'b01, 2'b00); // D vs tail R
    vecs[7]  = mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b01, 2'b00);
    vecs[8]  = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0001, 2'b01, 2'b00);
    vecs[9]  = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0010, 2'b00, 2'b00);
    vecs[10] = mk(0, 2'b00, 2'b01, 2'b00, 2'b00, 4'b0010, 2'b01, 2'b00);
    vecs[11] = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0001, 2'b00, 2'b00);
    vecs[12] = mk(0, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0001, 2'b00, 2'b00); // L opposite of R
    vecs[13] = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0001, 2'b00, 2'b00);
    vecs[14] = mk(0, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0001, 2'b01, 2'b00);
    vecs[15] = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00, 2'b00);
    vecs[16] = mk(0, 2'b00, 2'b01, 2'b00, 2'b00, 4'b0000, 2'b01, 2'b00);
    vecs[17] = mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b01, 2'b00);
    vecs[18] = mk(0, 2'b00, 2'b00, 2'b01, 2'b00, 4'b0000, 2'b01, 2'b00); // queue full
    vecs[19] = mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b01, 2'b00);
    vecs[20] = mk(0, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0000, 2'b01, 2'b01); // L dropped
    vecs[21] = mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b01, 2'b00); // pulse ends
    vecs[22] = mk(1, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0001, 2'b01, 2'b00); // full + TICK: accept L
    vecs[23] = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0010, 2'b01, 2'b00);
    vecs[24] = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0011, 2'b00, 2'b00);
    vecs[25] = mk(0, 2'b01, 2'b01, 2'b00, 2'b00, 4'b0011, 2'b01, 2'b00); // U beats R
    vecs[26] = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00, 2'b00);
    vecs[27] = mk(1, 2'b00, 2'b01, 2'b00, 2'b00, 4'b0000, 2'b01, 2'b00); // push + TICK, empty
    vecs[28] = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0001, 2'b00, 2'b00);
    vecs[29] = mk(0, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0001, 2'b01, 2'b00);
    vecs[30] = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00, 2'b00);
    vecs[31] = mk(0, 2'b00, 2'b01, 2'b00, 2'b10, 4'b0000, 2'b11, 2'b00); // p0 R, p1 L
    vecs[32] = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b1101, 2'b00, 2'b00);
    vecs[33] = mk(0, 2'b00, 2'b00, 2'b11, 2'b00, 4'b1101, 2'b11, 2'b00); // both queue D

    RESETN = 1'b0; TICK = 1'b0;
    BTNU = 2'b11; BTNR = 2'b00; BTND = 2'b00; BTNL = 2'b00;
    @(posedge CLK);
    step("reset", 0, 1'b0, mk(0, 2'b11, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00, 2'b00));

    for (int i = 0; i < 34; i++) step("vec", i, 1'b1, vecs[i]);

    // Reset with turns pending in both queues, then TICK must find nothing to apply.
    step("midreset", 0, 1'b0, mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00, 2'b00));
    step("midreset", 1, 1'b1, mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00, 2'b00));
    step("midreset", 2, 1'b1, mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00, 2'b00));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
